// File: rtl/wb_stage.sv
// Writeback stage: latches the MEM entry, retires it, drives the register-file write port and halts on jal x0,0.
// Optional CSR display outputs (HEX/LEDR) are built only when WB_CSR_EN is defined.

`ifndef IOPBITS
`define IOPBITS 5
`endif
`ifndef MEM_latch_WIDTH
`define MEM_latch_WIDTH (148 + `IOPBITS)
`endif

module wb_stage (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [`MEM_latch_WIDTH-1:0] from_MEM_latch,
  output logic [37:0]                 from_WB_to_DE,
  output logic [31:0]                 retired_count,
  output logic                        halted,
  output logic [23:0]                 hex_out,
  output logic [9:0]                  ledr_out
);

  typedef struct packed {
    logic                valid;
    logic [31:0]         inst;
    logic [31:0]         pc;
    logic [`IOPBITS-1:0] op_i;
    logic [31:0]         inst_count;
    logic                wr_reg;
    logic [4:0]          wregno;
    logic [31:0]         regval;
    logic                is_csrw;
    logic [11:0]         csr_addr;
  } mem_latch_t;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_e;

  localparam logic [31:0] HALT_INST = 32'h0000_006F;

  state_e      state_q, state_d;
  mem_latch_t  wb_q, wb_d, in_s;
  logic [31:0] retired_q, retired_d;
  logic        run, retire, halt_in_wb, wr_en;

  assign in_s       = from_MEM_latch;
  assign run        = (state_q == RUN);
  assign retire     = run && wb_q.valid;
  assign halt_in_wb = wb_q.valid && (wb_q.inst == HALT_INST);
  assign wr_en      = retire && wb_q.wr_reg && (wb_q.wregno != 5'd0);

  // The halting entry stays in the latch for its retire cycle; the state flips on
  // the edge that retires it, and the latch is frozen from then on.
  always_comb begin
    state_d   = state_q;
    wb_d      = wb_q;
    retired_d = retired_q;
    if (run && !halt_in_wb) wb_d = in_s;
    if (retire) retired_d = retired_q + 32'd1;
    if (retire && halt_in_wb) state_d = HALTED;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      wb_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wb_q      <= wb_d;
      retired_q <= retired_d;
    end
  end

  assign from_WB_to_DE = wr_en ? {1'b1, wb_q.wregno, wb_q.regval} : 38'd0;
  assign retired_count = retired_q;
  assign halted        = (state_q == HALTED);

`ifdef WB_CSR_EN
  logic [23:0] hex_q, hex_d;
  logic [9:0]  ledr_q, ledr_d;

  always_comb begin
    hex_d  = hex_q;
    ledr_d = ledr_q;
    if (retire && wb_q.is_csrw) begin
      case (wb_q.csr_addr)
        12'h800: hex_d  = wb_q.regval[23:0];
        12'h801: ledr_d = wb_q.regval[9:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_q  <= '0;
      ledr_q <= '0;
    end else begin
      hex_q  <= hex_d;
      ledr_q <= ledr_d;
    end
  end

  assign hex_out  = hex_q;
  assign ledr_out = ledr_q;
`else
  assign hex_out  = 24'd0;
  assign ledr_out = 10'd0;
`endif

  // Fields carried for other stages/debug that writeback itself never consumes.
  logic unused_fields;
  assign unused_fields = ^{wb_q.pc, wb_q.op_i, wb_q.inst_count, wb_q.is_csrw, wb_q.csr_addr};

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: register write, x0 suppression, CSR writes, halt, async reset, counter wrap.

`ifndef IOPBITS
`define IOPBITS 5
`endif
`ifndef MEM_latch_WIDTH
`define MEM_latch_WIDTH (148 + `IOPBITS)
`endif

module tb_wb_stage;

  logic                        clk;
  logic                        reset;
  logic [`MEM_latch_WIDTH-1:0] from_MEM_latch;
  logic [37:0]                 from_WB_to_DE;
  logic [31:0]                 retired_count;
  logic                        halted;
  logic [23:0]                 hex_out;
  logic [9:0]                  ledr_out;

  int tests = 0;
  int fails = 0;

`ifdef WB_CSR_EN
  localparam bit CSR_ON = 1'b1;
`else
  localparam bit CSR_ON = 1'b0;
`endif

  wb_stage dut (
    .clk           (clk),
    .reset         (reset),
    .from_MEM_latch(from_MEM_latch),
    .from_WB_to_DE (from_WB_to_DE),
    .retired_count (retired_count),
    .halted        (halted),
    .hex_out       (hex_out),
    .ledr_out      (ledr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [`MEM_latch_WIDTH-1:0] ent(input logic v, input logic [31:0] inst,
      input logic wr, input logic [4:0] rn, input logic [31:0] val,
      input logic csrw, input logic [11:0] ca);
    ent = {v, inst, 32'h0, {`IOPBITS{1'b0}}, 32'h0, wr, rn, val, csrw, ca};
  endfunction

  function automatic logic [37:0] wbv(input logic [4:0] rn, input logic [31:0] val);
    wbv = {1'b1, rn, val};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".wb"},     from_WB_to_DE, 0);
    check({tag, ".cnt"},    retired_count, 0);
    check({tag, ".halted"}, halted, 0);
    check({tag, ".hex"},    hex_out, 0);
    check({tag, ".ledr"},   ledr_out, 0);
  endtask

  localparam logic [31:0] ADD  = 32'h0000_0033;
  localparam logic [31:0] HALT = 32'h0000_006F;
  localparam logic [`MEM_latch_WIDTH-1:0] BUBBLE = '0;

  initial begin
    reset = 1'b1;
    from_MEM_latch = ent(1, ADD, 1, 5'd5, 32'h1234, 0, 12'h0);
    #12;
    check_all_zero("reset_init");
    @(negedge clk);
    reset = 1'b0;

    // Register write: visible the cycle after capture, counted on the following edge.
    from_MEM_latch = ent(1, ADD, 1, 5'd5, 32'h1234, 0, 12'h0);
    tick();
    check("add.wb", from_WB_to_DE, wbv(5'd5, 32'h1234));
    check("add.cnt_pre", retired_count, 0);
    from_MEM_latch = BUBBLE;
    tick();
    check("add.cnt", retired_count, 1);
    check("bubble.wb", from_WB_to_DE, 0);

    // x0 write suppressed but still retired.
    from_MEM_latch = ent(1, ADD, 1, 5'd0, 32'hFFFF, 0, 12'h0);
    tick();
    check("x0.wb", from_WB_to_DE, 0);
    from_MEM_latch = ent(0, ADD, 1, 5'd7, 32'h7777, 1, 12'h800);
    tick();
    check("x0.cnt", retired_count, 2);
    check("invalid.wb", from_WB_to_DE, 0);

    // CSR writes (invalid entry above must not touch hex).
    from_MEM_latch = ent(1, ADD, 0, 5'd0, 32'hABCDEF12, 1, 12'h800);
    tick();
    check("invalid.cnt", retired_count, 2);
    check("invalid.hex", hex_out, 0);
    from_MEM_latch = ent(1, ADD, 1, 5'd9, 32'h0000_03FF, 1, 12'h801);
    tick();
    check("csr800.hex", hex_out, CSR_ON ? 24'hCDEF12 : 24'h0);
    check("csr801.wb", from_WB_to_DE, wbv(5'd9, 32'h3FF));
    from_MEM_latch = ent(1, ADD, 0, 5'd0, 32'h0, 1, 12'h802);
    tick();
    check("csr801.ledr", ledr_out, CSR_ON ? 10'h3FF : 10'h0);
    from_MEM_latch = BUBBLE;
    tick();
    check("csr802.hex", hex_out, CSR_ON ? 24'hCDEF12 : 24'h0);
    check("csr802.ledr", ledr_out, CSR_ON ? 10'h3FF : 10'h0);
    check("csr.cnt", retired_count, 5);

    // Async reset between edges clears everything at once.
    #2 reset = 1'b1;
    #1 check_all_zero("reset_mid1");
    @(negedge clk);
    reset = 1'b0;

    // Halt: three entries, the third is jal x0,0, then five more that must be ignored.
    from_MEM_latch = ent(1, ADD, 1, 5'd1, 32'h11, 0, 12'h0);
    tick();
    from_MEM_latch = ent(1, ADD, 1, 5'd2, 32'h22, 0, 12'h0);
    tick();
    from_MEM_latch = ent(1, HALT, 1, 5'd3, 32'h77, 0, 12'h0);
    tick();
    check("halt.wb", from_WB_to_DE, wbv(5'd3, 32'h77));
    check("halt.halted_pre", halted, 0);
    check("halt.cnt_pre", retired_count, 2);
    for (int i = 0; i < 5; i++) begin
      from_MEM_latch = ent(1, ADD, 1, 5'd4, 32'h44 + i, 1, 12'h800);
      tick();
      check("post_halt.wb", from_WB_to_DE, 0);
      check("post_halt.halted", halted, 1);
      check("post_halt.cnt", retired_count, 3);
      check("post_halt.hex", hex_out, 0);
    end

    #2 reset = 1'b1;
    #1 check_all_zero("reset_halted");
    @(negedge clk);
    reset = 1'b0;

    // Counter wrap from all-ones.
    from_MEM_latch = ent(1, ADD, 1, 5'd6, 32'h66, 0, 12'h0);
    tick();
    check("wrap.wb", from_WB_to_DE, wbv(5'd6, 32'h66));
    force dut.retired_q = 32'hFFFF_FFFF;
    #1 release dut.retired_q;
    check("wrap.preload", retired_count, 32'hFFFF_FFFF);
    from_MEM_latch = BUBBLE;
    tick();
    check("wrap.cnt", retired_count, 0);

    // Reset with an entry in flight: it is discarded, not retried.
    from_MEM_latch = ent(1, ADD, 1, 5'd8, 32'h88, 0, 12'h0);
    tick();
    from_MEM_latch = ent(1, ADD, 1, 5'd10, 32'hAA, 0, 12'h0);
    tick();
    check("inflight.wb", from_WB_to_DE, wbv(5'd10, 32'hAA));
    check("inflight.cnt", retired_count, 1);
    #2 reset = 1'b1;
    #1 check_all_zero("reset_inflight");
    @(negedge clk);
    reset = 1'b0;
    from_MEM_latch = ent(1, ADD, 1, 5'd12, 32'hCC, 0, 12'h0);
    tick();
    check("resume.wb", from_WB_to_DE, wbv(5'd12, 32'hCC));
    check("resume.cnt", retired_count, 0);
    from_MEM_latch = BUBBLE;
    tick();
    check("resume.cnt2", retired_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
